iigs_irq_ctrl: RTL and testbench

IIGS_IRQ_CTRL -- requirements
Module: iigs_irq_ctrl

---
 rtl/iigs_irq_ctrl_pkg.sv | 40 ++++
 rtl/iigs_irq_ctrl_if.sv | 18 +
 rtl/iigs_irq_ctrl_latch.sv | 25 ++
 rtl/iigs_irq_ctrl.sv | 126 ++++++++++++
 tb/tb_iigs_irq_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/iigs_irq_ctrl_pkg.sv
// iigs_irq_pkg -- shared constants for the IIgs interrupt controller.
//   Soft-switch address low bytes ($C0xx), register bit positions and the
//   status-bit index used to address the latch array in iigs_irq_ctrl.
//   Optional feature macro: IIGS_QTRSEC_IRQ_EN (quarter-second interrupt).
package iigs_irq_pkg;

  localparam logic [7:0] ADDR_C023 = 8'h23;  // 1SEC/scanline enables + status
  localparam logic [7:0] ADDR_C032 = 8'h32;  // 1SEC/scanline status clear
  localparam logic [7:0] ADDR_C041 = 8'h41;  // interrupt enable register
  localparam logic [7:0] ADDR_C046 = 8'h46;  // QS/VBL status
  localparam logic [7:0] ADDR_C047 = 8'h47;  // QS/VBL status clear

  // C023 bit positions
  localparam int C023_ANY  = 7;
  localparam int C023_S1   = 6;
  localparam int C023_SL   = 5;
  localparam int C023_EN1  = 2;
  localparam int C023_ENSL = 1;

  // C032 clear-on-zero bit positions
  localparam int C032_S1 = 6;
  localparam int C032_SL = 5;

  // C041 enable bit positions
  localparam int C041_ENQ = 4;
  localparam int C041_ENV = 3;

  // C046 status bit positions
  localparam int C046_QS = 4;
  localparam int C046_VB = 3;

  localparam int NUM_STAT = 4;
  typedef enum logic [1:0] {
    ST_S1 = 2'd0,
    ST_SL = 2'd1,
    ST_QS = 2'd2,
    ST_VB = 2'd3
  } stat_idx_e;

endpackage

// File: rtl/iigs_irq_ctrl_if.sv
// iigs_irq_ctrl_if -- CPU soft-switch bus between the bus master and the
//   interrupt controller.
//   cen/strobe : bus clock enable / one-cycle access qualifier
//   addr/rw    : $C0xx low byte, 1=read 0=write
//   din/dout   : write data / combinational read data
//   hit        : address decodes to one of this block's registers
interface iigs_irq_ctrl_if;
  logic       cen;
  logic       strobe;
  logic [7:0] addr;
  logic       rw;
  logic [7:0] din;
  logic [7:0] dout;
  logic       hit;

  modport master (output cen, strobe, addr, rw, din, input dout, hit);
  modport slave  (input cen, strobe, addr, rw, din, output dout, hit);
endinterface

// File: rtl/iigs_irq_ctrl_latch.sv
// irq_latch -- one set-dominant interrupt status bit.
//   clk/rst : clock, asynchronous active-high reset
//   en_i    : source enable; gates set only, never clears a pending bit
//   set_i   : event pulse
//   clr_i   : software clear; loses to a simultaneous enabled set
//   q_o     : status
module irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);
  logic q_q, q_d;

  assign q_d = (set_i & en_i) | (q_q & ~clr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/iigs_irq_ctrl.sv
// iigs_irq_ctrl -- Apple IIgs 1SEC / scanline / quarter-second / VBL
//   interrupt enables, status and CPU irq.
//   CLK_14M, reset : clock, asynchronous active-high reset
//   bus            : soft-switch bus (iigs_irq_ctrl_if.slave)
//   onesecond_irq, qtrsecond_irq, scanline_irq : one-cycle event pulses
//   vbl            : vertical-blank level (rising edge is the event)
//   irq            : registered OR of all status bits
//   Macro IIGS_QTRSEC_IRQ_EN enables QS/ENQ; otherwise QS is stuck at 0
//   and C041.4 reads 0.
module iigs_irq_ctrl
  import iigs_irq_pkg::*;
(
  input  logic             CLK_14M,
  input  logic             reset,
  iigs_irq_ctrl_if.slave   bus,
  input  logic             onesecond_irq,
  input  logic             qtrsecond_irq,
  input  logic             scanline_irq,
  input  logic             vbl,
  output logic             irq
);
  logic       wr;
  logic       en1_q, en1_d, ensl_q, ensl_d;
  logic [3:0] c041_q, c041_d;   // ENV + three plain storage bits
  logic       enq;
  logic       vbl_d_q;
  logic       irq_q;

  logic [NUM_STAT-1:0] stat_en, stat_set, stat_clr, stat_q;

  assign wr = bus.strobe & bus.cen & ~bus.rw;

  always_comb begin
    en1_d  = en1_q;
    ensl_d = ensl_q;
    c041_d = c041_q;
    if (wr && bus.addr == ADDR_C023) begin
      en1_d  = bus.din[C023_EN1];
      ensl_d = bus.din[C023_ENSL];
    end
    if (wr && bus.addr == ADDR_C041) c041_d = bus.din[3:0];
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      en1_q   <= 1'b0;
      ensl_q  <= 1'b0;
      c041_q  <= 4'h0;
      vbl_d_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      en1_q   <= en1_d;
      ensl_q  <= ensl_d;
      c041_q  <= c041_d;
      vbl_d_q <= vbl;
      irq_q   <= |stat_q;
    end
  end

`ifdef IIGS_QTRSEC_IRQ_EN
  logic enq_q, enq_d;
  assign enq_d = (wr && bus.addr == ADDR_C041) ? bus.din[C041_ENQ] : enq_q;
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) enq_q <= 1'b0;
    else       enq_q <= enq_d;
  end
  assign enq = enq_q;
`else
  // Enable tied low: the QS latch can never set, so it holds its reset 0.
  assign enq = 1'b0;
`endif

  always_comb begin
    stat_en[ST_S1]  = en1_q;
    stat_en[ST_SL]  = ensl_q;
    stat_en[ST_QS]  = enq;
    stat_en[ST_VB]  = c041_q[C041_ENV];

    stat_set[ST_S1] = onesecond_irq;
    stat_set[ST_SL] = scanline_irq;
    stat_set[ST_QS] = qtrsecond_irq;
    stat_set[ST_VB] = vbl & ~vbl_d_q;

    // C032 clears on written 0 bits; C047 clears regardless of data
    stat_clr[ST_S1] = wr && bus.addr == ADDR_C032 && !bus.din[C032_S1];
    stat_clr[ST_SL] = wr && bus.addr == ADDR_C032 && !bus.din[C032_SL];
    stat_clr[ST_QS] = wr && bus.addr == ADDR_C047;
    stat_clr[ST_VB] = wr && bus.addr == ADDR_C047;
  end

  irq_latch u_lat [NUM_STAT-1:0] (
    .clk   (CLK_14M),
    .rst   (reset),
    .en_i  (stat_en),
    .set_i (stat_set),
    .clr_i (stat_clr),
    .q_o   (stat_q)
  );

  always_comb begin
    bus.dout = 8'h00;
    if (bus.rw) begin
      case (bus.addr)
        ADDR_C023: begin
          bus.dout[C023_ANY]  = stat_q[ST_S1] | stat_q[ST_SL];
          bus.dout[C023_S1]   = stat_q[ST_S1];
          bus.dout[C023_SL]   = stat_q[ST_SL];
          bus.dout[C023_EN1]  = en1_q;
          bus.dout[C023_ENSL] = ensl_q;
        end
        ADDR_C041: bus.dout = {3'b000, enq, c041_q};
        ADDR_C046: begin
          bus.dout[C046_QS] = stat_q[ST_QS];
          bus.dout[C046_VB] = stat_q[ST_VB];
        end
        default:   bus.dout = 8'h00;
      endcase
    end
  end

  assign bus.hit = (bus.addr == ADDR_C023) || (bus.addr == ADDR_C032) ||
                   (bus.addr == ADDR_C041) || (bus.addr == ADDR_C046) ||
                   (bus.addr == ADDR_C047);

  assign irq = irq_q;
endmodule

// File: tb/tb_iigs_irq_ctrl.sv
// tb_iigs_irq_ctrl -- directed self-checking bench for iigs_irq_ctrl.
module tb_iigs_irq_ctrl;
  logic CLK_14M = 1'b0;
  logic reset;
  logic onesecond_irq, qtrsecond_irq, scanline_irq, vbl;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  iigs_irq_ctrl_if bus ();

  iigs_irq_ctrl dut (
    .CLK_14M       (CLK_14M),
    .reset         (reset),
    .bus           (bus.slave),
    .onesecond_irq (onesecond_irq),
    .qtrsecond_irq (qtrsecond_irq),
    .scanline_irq  (scanline_irq),
    .vbl           (vbl),
    .irq           (irq)
  );

  always #5 CLK_14M = ~CLK_14M;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Read is combinational; sampled 1ns after a falling edge.
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.addr = a;
    bus.rw   = 1'b1;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK_14M);
    bus.addr = a; bus.din = d; bus.rw = 1'b0; bus.strobe = 1'b1;
    @(negedge CLK_14M);
    bus.strobe = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic pulse(input int which);
    @(negedge CLK_14M);
    case (which)
      0: onesecond_irq = 1'b1;
      1: scanline_irq  = 1'b1;
      default: qtrsecond_irq = 1'b1;
    endcase
    @(negedge CLK_14M);
    onesecond_irq = 1'b0; scanline_irq = 1'b0; qtrsecond_irq = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    #1;
    chk(tag, {7'b0, irq}, {7'b0, exp});
  endtask

  initial begin
    reset = 1'b1;
    onesecond_irq = 1'b0; qtrsecond_irq = 1'b0; scanline_irq = 1'b0; vbl = 1'b0;
    bus.cen = 1'b1; bus.strobe = 1'b0; bus.rw = 1'b1; bus.addr = 8'h00; bus.din = 8'h00;
    repeat (3) @(negedge CLK_14M);
    pulse(0);                                 // dropped while in reset
    reset = 1'b0;
    @(negedge CLK_14M);

    // reset state and decode
    chk_irq("rst_irq", 1'b0);
    rd("rst_c023", 8'h23, 8'h00);
    rd("rst_c046", 8'h46, 8'h00);
    rd("rst_c041", 8'h41, 8'h00);
    bus.addr = 8'h23; #1; chk("hit_23", {7'b0, bus.hit}, 8'h01);
    bus.addr = 8'h32; #1; chk("hit_32", {7'b0, bus.hit}, 8'h01);
    bus.addr = 8'h47; #1; chk("hit_47", {7'b0, bus.hit}, 8'h01);
    bus.addr = 8'h24; #1; chk("hit_24", {7'b0, bus.hit}, 8'h00);
    bus.addr = 8'h33; bus.rw = 1'b1; #1; chk("dout_nohit", bus.dout, 8'h00);

    // write without cen is ignored
    @(negedge CLK_14M);
    bus.cen = 1'b0; bus.addr = 8'h23; bus.din = 8'h04; bus.rw = 1'b0; bus.strobe = 1'b1;
    @(negedge CLK_14M);
    bus.cen = 1'b1; bus.strobe = 1'b0; bus.rw = 1'b1;
    rd("nocen_c023", 8'h23, 8'h00);

    // 1SEC
    wr(8'h23, 8'h04);
    rd("en1_c023", 8'h23, 8'h04);
    pulse(0);
    rd("s1_c023", 8'h23, 8'hC4);
    rd("s1_c023_again", 8'h23, 8'hC4);       // read has no side effect
    chk_irq("s1_irq_lat", 1'b0);
    @(negedge CLK_14M);
    chk_irq("s1_irq", 1'b1);
    wr(8'h32, 8'hBF);
    rd("s1clr_c023", 8'h23, 8'h04);
    @(negedge CLK_14M);
    chk_irq("s1clr_irq", 1'b0);

    // disabled scanline event
    wr(8'h23, 8'h00);
    pulse(1);
    rd("sl_dis_c023", 8'h23, 8'h00);
    @(negedge CLK_14M);
    chk_irq("sl_dis_irq", 1'b0);

    // scanline set, enable drop keeps status, C032 bit5=1 keeps, bit5=0 clears
    wr(8'h23, 8'h02);
    pulse(1);
    rd("sl_c023", 8'h23, 8'hA2);
    wr(8'h23, 8'h00);
    rd("sl_endrop_c023", 8'h23, 8'hA0);
    wr(8'h32, 8'hFF);
    rd("sl_keep_c023", 8'h23, 8'hA0);
    wr(8'h32, 8'hDF);
    rd("sl_clr_c023", 8'h23, 8'h00);

    // VBL: long high level sets once
    wr(8'h41, 8'h08);
    rd("env_c041", 8'h41, 8'h08);
    @(negedge CLK_14M);
    vbl = 1'b1;
    repeat (1000) @(negedge CLK_14M);
    rd("vb_c046", 8'h46, 8'h08);
    chk_irq("vb_irq", 1'b1);
    wr(8'h47, 8'h00);
    rd("vbclr_c046", 8'h46, 8'h00);
    repeat (3) @(negedge CLK_14M);
    rd("vbhold_c046", 8'h46, 8'h00);
    chk_irq("vbclr_irq", 1'b0);
    vbl = 1'b0;
    repeat (2) @(negedge CLK_14M);

    // VB collision: edge and C047 clear in the same cycle -> set wins
    bus.addr = 8'h47; bus.din = 8'h00; bus.rw = 1'b0; bus.strobe = 1'b1; vbl = 1'b1;
    @(negedge CLK_14M);
    bus.strobe = 1'b0; bus.rw = 1'b1;
    rd("vb_coll_c046", 8'h46, 8'h08);
    wr(8'h47, 8'h00);
    vbl = 1'b0;
    rd("vb_coll_clr", 8'h46, 8'h00);
    wr(8'h41, 8'h00);
    @(negedge CLK_14M);

`ifdef IIGS_QTRSEC_IRQ_EN
    wr(8'h41, 8'h10);
    rd("enq_c041", 8'h41, 8'h10);
    bus.addr = 8'h47; bus.din = 8'h00; bus.rw = 1'b0; bus.strobe = 1'b1; qtrsecond_irq = 1'b1;
    @(negedge CLK_14M);
    bus.strobe = 1'b0; bus.rw = 1'b1; qtrsecond_irq = 1'b0;
    rd("qs_coll_c046", 8'h46, 8'h10);
    @(negedge CLK_14M);
    chk_irq("qs_irq", 1'b1);
    wr(8'h47, 8'h00);
    rd("qs_clr_c046", 8'h46, 8'h00);
    wr(8'h41, 8'h00);
`else
    wr(8'h41, 8'h1F);
    rd("noqs_c041", 8'h41, 8'h0F);
    pulse(2);
    rd("noqs_c046", 8'h46, 8'h00);
    @(negedge CLK_14M);
    chk_irq("noqs_irq", 1'b0);
    wr(8'h41, 8'h00);
`endif

    // reset with S1 and VB pending
    wr(8'h23, 8'h04);
    wr(8'h41, 8'h08);
    pulse(0);
    @(negedge CLK_14M);
    vbl = 1'b1;
    @(negedge CLK_14M);
    rd("pre_rst_c023", 8'h23, 8'hC4);
    rd("pre_rst_c046", 8'h46, 8'h08);
    chk_irq("pre_rst_irq", 1'b1);
    reset = 1'b1;
    chk_irq("mid_rst_irq", 1'b0);
    rd("mid_rst_c023", 8'h23, 8'h00);
    rd("mid_rst_c046", 8'h46, 8'h00);
    rd("mid_rst_c041", 8'h41, 8'h00);
    @(negedge CLK_14M);
    reset = 1'b0;
    vbl = 1'b0;
    repeat (2) @(negedge CLK_14M);
    chk_irq("post_rst_irq", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
